// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter that serialises two requesters onto one fixed-latency memory port.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default: fixed data priority).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int         BE_W      = DATA_W / 8;
  localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state, state_next;
  logic [3:0]          cnt, cnt_next;
  logic                any_req;
  logic                grant_data;
  logic                last_wait;
  logic                lat_store;
  logic [ADDR_W-1:0]   lat_addr;
  logic [BE_W-1:0]     lat_be;
  logic [DATA_W-1:0]   lat_wdata;

  assign any_req   = if_req | d_req;
  assign last_wait = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On contention hand the grant to whichever port did not win last time.
    if (if_req && d_req) grant_data = ~owner;
    else                 grant_data = d_req;
`else
    grant_data = d_req;
`endif
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (any_req) state_next = ACCESS;
      end
      ACCESS: begin
        state_next = WAIT;
        cnt_next   = WAIT_LOAD;
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      lat_store <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // The grant cycle is the only point where requester fields are observed.
      if (state == IDLE && any_req) begin
        owner     <= grant_data;
        lat_store <= grant_data & d_we;
        lat_addr  <= grant_data ? d_addr : if_addr;
        lat_be    <= (grant_data && d_we) ? d_be : '0;
        lat_wdata <= grant_data ? d_wdata : '0;
      end
      if (last_wait) begin
        if (!owner)          if_rdata <= mem_rdata;
        else if (!lat_store) d_rdata  <= mem_rdata;
      end
    end
  end

  // Memory-side fields are gated so the bus reads as zero outside the strobe cycle.
  assign mem_en    = (state == ACCESS);
  assign mem_addr  = mem_en ? lat_addr  : '0;
  assign mem_we    = mem_en ? lat_be    : '0;
  assign mem_wdata = mem_en ? lat_wdata : '0;

  assign if_ready  = (state == RESP) && !owner;
  assign d_ready   = (state == RESP) &&  owner;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences,
// and a randomized run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic          clk;
  logic          rst;

  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_ready, d_ready, mem_en, busy, owner;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;

  logic          b_if_req, b_d_req, b_d_we;
  logic [AW-1:0] b_if_addr, b_d_addr;
  logic [BW-1:0] b_d_be;
  logic [DW-1:0] b_d_wdata, b_mem_rdata;
  logic          b_if_ready, b_d_ready, b_mem_en, b_busy, b_owner;
  logic [DW-1:0] b_if_rdata, b_d_rdata, b_mem_wdata;
  logic [BW-1:0] b_mem_we;
  logic [AW-1:0] b_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_mem_we;
    logic [31:0] exp_mem_wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [7];

  // Reference model state: one outstanding transaction described by its grant cycle.
  bit          m_act, m_data, m_we, m_owner;
  int          m_g;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_d_rd;
  logic [3:0]  m_be;
  int          pend_cyc;
  logic [31:0] pend_val;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%h, expected 0x%h", name, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a, input int c);
    return a ^ {16'(c), 16'h9E37};
  endfunction

  task automatic run_reset_check();
    rst = 1'b1;
    repeat (3) next_cycle();
    sample();
    check("reset mem_en",    32'(mem_en),    32'd0);
    check("reset mem_we",    32'(mem_we),    32'd0);
    check("reset mem_addr",  mem_addr,       32'd0);
    check("reset mem_wdata", mem_wdata,      32'd0);
    check("reset if_ready",  32'(if_ready),  32'd0);
    check("reset d_ready",   32'(d_ready),   32'd0);
    check("reset if_rdata",  if_rdata,       32'd0);
    check("reset d_rdata",   d_rdata,        32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset owner",     32'(owner),     32'd0);
    check("reset b_busy",    32'(b_busy),    32'd0);
    next_cycle();
    rst = 1'b0;
  endtask

  // Load at MEM_LAT=4: strobe at t+1, data valid only at t+5, ready at t+6.
  task automatic run_lat4();
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h40; b_d_be = '0; b_d_wdata = '0;
    b_mem_rdata = $urandom;
    sample();
    check("lat4 idle busy", 32'(b_busy), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      if (k == 1) b_d_req = 1'b0;
      b_mem_rdata = (k == 5) ? 32'hCAFE_F00D : $urandom;
      sample();
      check($sformatf("lat4 t+%0d mem_en", k), 32'(b_mem_en), 32'(k == 1));
      if (k == 1) check("lat4 mem_addr", b_mem_addr, 32'h40);
      check($sformatf("lat4 t+%0d busy", k), 32'(b_busy), 32'd1);
      check($sformatf("lat4 t+%0d d_ready", k), 32'(b_d_ready), 32'(k == 6));
      if (k == 6) check("lat4 d_rdata", b_d_rdata, 32'hCAFE_F00D);
    end
    next_cycle();
    sample();
    check("lat4 t+7 busy", 32'(b_busy), 32'd0);
    next_cycle();
  endtask

  task automatic run_table();
    vec_t v;
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      if (v.is_data) begin
        d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
        if_req = 1'b1; if_addr = v.addr;
      end
      mem_rdata = $urandom;
      sample();
      check($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);

      // Requests drop and fields scramble right after the grant; the transaction must not notice.
      next_cycle();
      if_req = 1'b0; d_req = 1'b0;
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_be = 4'($urandom); d_we = 1'($urandom);
      mem_rdata = $urandom;
      sample();
      check($sformatf("vec%0d mem_en", i),    32'(mem_en),  32'd1);
      check($sformatf("vec%0d mem_addr", i),  mem_addr,     v.addr);
      check($sformatf("vec%0d mem_we", i),    32'(mem_we),  32'(v.exp_mem_we));
      check($sformatf("vec%0d mem_wdata", i), mem_wdata,    v.exp_mem_wdata);
      check($sformatf("vec%0d access busy", i), 32'(busy), 32'd1);

      next_cycle();
      mem_rdata = v.rdata;
      sample();
      check($sformatf("vec%0d wait mem_en", i),   32'(mem_en), 32'd0);
      check($sformatf("vec%0d wait mem_addr", i), mem_addr,    32'd0);
      check($sformatf("vec%0d wait mem_bus", i),  32'(mem_we) | mem_wdata, 32'd0);
      check($sformatf("vec%0d wait readies", i),  32'(if_ready | d_ready), 32'd0);

      next_cycle();
      mem_rdata = $urandom;
      sample();
      check($sformatf("vec%0d if_ready", i), 32'(if_ready), 32'(!v.is_data));
      check($sformatf("vec%0d d_ready", i),  32'(d_ready),  32'(v.is_data));
      check($sformatf("vec%0d if_rdata", i), if_rdata,      v.exp_if_rdata);
      check($sformatf("vec%0d d_rdata", i),  d_rdata,       v.exp_d_rdata);
      check($sformatf("vec%0d owner", i),    32'(owner),    32'(v.is_data));

      next_cycle();
      sample();
      check($sformatf("vec%0d post readies", i), 32'(if_ready | d_ready), 32'd0);
      check($sformatf("vec%0d post busy", i),    32'(busy), 32'd0);
      next_cycle();
      sample();
      check($sformatf("vec%0d no restart", i), 32'(mem_en | busy), 32'd0);
      next_cycle();
    end
  endtask

  task automatic run_arb();
    bit exp_win [4];
    int last = -1;
    bit found, got;
`ifdef MEM_ARB_RR_EN
    exp_win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_win = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_be = '0; d_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      got   = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        mem_rdata = $urandom;
        sample();
        if (if_ready || d_ready) begin
          found = 1'b1;
          got   = d_ready;
          check("arb exclusive readies", 32'(if_ready && d_ready), 32'd0);
          if (last >= 0) check("arb ready spacing", 32'(cyc - last), 32'(3 + LAT_A));
          last = cyc;
        end
        next_cycle();
      end
      check($sformatf("arb grant%0d seen", k), 32'(found), 32'd1);
      check($sformatf("arb grant%0d winner", k), 32'(got), 32'(exp_win[k]));
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int w = 0; w < 20; w++) begin
      sample();
      if (!busy) break;
      next_cycle();
    end
    check("arb drained", 32'(busy), 32'd0);
    next_cycle();
  endtask

  task automatic run_reset_mid();
    bit found = 1'b0;
    if_req = 1'b1; if_addr = 32'h3000;
    mem_rdata = $urandom;
    sample();
    next_cycle();
    sample();
    check("rstmid access mem_en", 32'(mem_en), 32'd1);
    next_cycle();
    rst = 1'b1;
    sample();
    check("rstmid wait busy", 32'(busy), 32'd1);
    next_cycle();
    rst = 1'b0;
    sample();
    check("rstmid busy cleared", 32'(busy), 32'd0);
    check("rstmid no ready", 32'(if_ready | d_ready), 32'd0);
    check("rstmid mem_en", 32'(mem_en), 32'd0);
    check("rstmid if_rdata", if_rdata, 32'd0);
    check("rstmid owner", 32'(owner), 32'd0);
    next_cycle();
    sample();
    check("rstmid restart mem_en", 32'(mem_en), 32'd1);
    check("rstmid restart addr", mem_addr, 32'h3000);
    if_req = 1'b0;
    for (int w = 0; w < 8 && !found; w++) begin
      next_cycle();
      sample();
      if (if_ready) found = 1'b1;
    end
    check("rstmid restart ready", 32'(found), 32'd1);
    next_cycle();
  endtask

  // Reference model: each granted transaction is described only by its grant cycle g;
  // strobe at g+1, ready at g+2+LAT, next grant possible the cycle after ready.
  task automatic model_step();
    bit e_en, rdy;
    e_en = m_act && (cyc == m_g + 1);
    rdy  = m_act && (cyc == m_g + 2 + LAT_A);
    if (rdy) begin
      if (!m_data)   m_if_rd = rd_fn(m_addr, m_g + 1);
      else if (!m_we) m_d_rd = rd_fn(m_addr, m_g + 1);
    end
    check("rand mem_en",    32'(mem_en),   32'(e_en));
    check("rand mem_addr",  mem_addr,      e_en ? m_addr : 32'd0);
    check("rand mem_we",    32'(mem_we),   (e_en && m_data && m_we) ? 32'(m_be) : 32'd0);
    check("rand mem_wdata", mem_wdata,     (e_en && m_data) ? m_wdata : 32'd0);
    check("rand busy",      32'(busy),     32'(m_act));
    check("rand owner",     32'(owner),    32'(m_owner));
    check("rand if_ready",  32'(if_ready), 32'(rdy && !m_data));
    check("rand d_ready",   32'(d_ready),  32'(rdy && m_data));
    check("rand if_rdata",  if_rdata,      m_if_rd);
    check("rand d_rdata",   d_rdata,       m_d_rd);
    if (rdy) begin
      m_act = 1'b0;
    end else if (!m_act && (if_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
      m_data = (if_req && d_req) ? !m_owner : d_req;
`else
      m_data = d_req;
`endif
      m_act   = 1'b1;
      m_g     = cyc;
      m_addr  = m_data ? d_addr : if_addr;
      m_we    = m_data && d_we;
      m_be    = d_be;
      m_wdata = d_wdata;
      m_owner = m_data;
    end
  endtask

  task automatic rand_cycle(input bit active);
    if (active) begin
      if ($urandom_range(3) == 0) if_req = ~if_req;
      if ($urandom_range(3) == 0) d_req  = ~d_req;
      if ($urandom_range(1) == 0) if_addr = $urandom;
      if ($urandom_range(1) == 0) begin
        d_addr = $urandom; d_wdata = $urandom;
        d_be = 4'($urandom); d_we = 1'($urandom);
      end
    end else begin
      if_req = 1'b0; d_req = 1'b0;
    end
    mem_rdata = (cyc == pend_cyc) ? pend_val : $urandom;
    sample();
    model_step();
    if (mem_en) begin
      pend_cyc = cyc + LAT_A;
      pend_val = rd_fn(mem_addr, cyc);
    end
    next_cycle();
  endtask

  task automatic run_random();
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_act = 1'b0; m_owner = 1'b0; m_data = 1'b0; m_we = 1'b0; m_g = 0;
    m_if_rd = '0; m_d_rd = '0; m_addr = '0; m_wdata = '0; m_be = '0;
    pend_cyc = -1; pend_val = '0;
    for (int k = 0; k < 3000; k++) rand_cycle(1'b1);
    for (int k = 0; k < 12; k++)   rand_cycle(1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h0050_0093,
                4'h0, 32'h0,         32'h0050_0093, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF, 32'h1111_1111,
                4'hF, 32'hDEAD_BEEF, 32'h0050_0093, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0300, 32'h0,         32'hA5A5_1234,
                4'h0, 32'h0,         32'h0050_0093, 32'hA5A5_1234};
    vecs[3] = '{1'b1, 1'b1, 4'h0, 32'h0000_0204, 32'h1234_5678, 32'h2222_2222,
                4'h0, 32'h1234_5678, 32'h0050_0093, 32'hA5A5_1234};
    vecs[4] = '{1'b1, 1'b1, 4'h5, 32'h0000_0208, 32'hCAFE_BABE, 32'h3333_3333,
                4'h5, 32'hCAFE_BABE, 32'h0050_0093, 32'hA5A5_1234};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h8000_0001,
                4'h0, 32'h0,         32'h8000_0001, 32'hA5A5_1234};
    vecs[6] = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF,
                4'h0, 32'h0,         32'h8000_0001, 32'hFFFF_FFFF};

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    b_d_req = 1'b0; b_d_we = 1'b0; b_d_be = '0; b_d_addr = '0; b_d_wdata = '0;
    b_mem_rdata = '0;

    run_reset_check();
    run_lat4();
    run_table();
    run_arb();
    run_reset_mid();
    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of requester and memory ports.
REQ-002 Parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 if_req  in  1  fetch request, held high until if_ready.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_ready  out  1  one-cycle pulse, fetch complete, if_rdata valid.
REQ-009 if_rdata  out  DATA_W  fetched word, held until next fetch completes.
REQ-010 d_req  in  1  load/store request, held high until d_ready.
REQ-011 d_we  in  1  1 = store, 0 = load.
REQ-012 d_be  in  DATA_W/8  store byte enables.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_ready  out  1  one-cycle pulse, data access complete.
REQ-016 d_rdata  out  DATA_W  load data, held until next load completes.
REQ-017 mem_en  out  1  memory access strobe, one cycle per transaction.
REQ-018 mem_we  out  DATA_W/8  byte write enables, valid with mem_en.
REQ-019 mem_addr  out  ADDR_W  memory address, valid with mem_en.
REQ-020 mem_wdata  out  DATA_W  memory write data, valid with mem_en.
REQ-021 mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
REQ-022 busy  out  1  high whenever state is not IDLE.
REQ-023 owner  out  1  0 = fetch, 1 = data; current/last grant.

Function
REQ-024 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-025 IDLE: if any req high, grant, latch addr/we/be/wdata of winner, go ACCESS; else stay.
REQ-026 ACCESS: mem_en=1 for exactly one cycle with latched fields; mem_we = latched be if store, else 0; go WAIT.
REQ-027 WAIT: stay MEM_LAT cycles via 4-bit down-counter; on final cycle capture mem_rdata into winner's rdata if load; go RESP.
REQ-028 RESP: assert winner's ready for one cycle; go IDLE.
REQ-029 Latency: req sampled in IDLE at cycle t -> mem_en at t+1 -> ready at t+2+MEM_LAT (t+3 at MEM_LAT=1).
REQ-030 Stores take same latency as loads; d_rdata unchanged by a store.
REQ-031 Default arbitration when both request in IDLE: data wins (fixed priority).
REQ-032 Req or request fields changing after the grant cycle SHALL be ignored; transaction completes and ready still pulses.
REQ-033 Req still high in the IDLE cycle after RESP SHALL start a new transaction; no back-to-back ready on consecutive cycles.
REQ-034 Store with d_be=0: mem_en pulses, mem_we=0, d_ready pulses normally.
REQ-035 mem_addr, mem_wdata, mem_we SHALL be 0 whenever mem_en=0.
REQ-036 if_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-037 On rst: state IDLE, counter 0, mem_en/mem_we/mem_addr/mem_wdata 0, if_ready/d_ready 0, if_rdata/d_rdata 0, busy 0, owner 0.
REQ-038 Reset mid-transaction aborts it: no ready pulse issued; req sampled anew in first IDLE cycle after rst falls.

Configuration
REQ-039 Macro MEM_ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not equal to owner; owner resets to 0 so data wins first contest.
REQ-040 MEM_ARB_RR_EN undefined: fixed data priority per REQ-031; fetch may starve under continuous data requests.

Verification
REQ-041 MEM_LAT=1, if_req at t with if_addr=0x100, mem_rdata=0x00500093 -> mem_en/mem_addr=0x100 at t+1, if_ready with if_rdata=0x00500093 at t+3.
REQ-042 d_req store d_addr=0x200 d_wdata=0xDEADBEEF d_be=0xF -> one mem_en with mem_we=0xF, d_ready at t+3, d_rdata unchanged.
REQ-043 if_req and d_req both high at same IDLE cycle, held continuously -> without macro: data, data, data...; with MEM_ARB_RR_EN: data, fetch, data, fetch.
REQ-044 MEM_LAT=4, load d_addr=0x40 -> mem_en at t+1, capture at t+5, d_ready at t+6, busy high t+1..t+6.
REQ-045 rst asserted during WAIT -> next cycle busy=0, no ready pulse; if_req held through reset -> new fetch mem_en two cycles after rst falls.
REQ-046 Drop d_req one cycle after grant -> d_ready still pulses at t+2+MEM_LAT; no second transaction.
